// File: rtl/sub_bytes_serial_if.sv
// Valid/ready bus for the serial SubBytes stage: input state handshake,
// output state handshake and a busy indication.
`timescale 1ns/1ps
interface sub_bytes_serial_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_out, busy
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_out, busy
   );
endinterface

// File: rtl/sub_bytes_serial.sv
// AES SubBytes applied LANES bytes per cycle to a 128-bit state held in W.
// Byte k of the state is bits [127-8k -: 8] (FIPS-197 order).
`timescale 1ns/1ps
module sub_bytes_serial #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   sub_bytes_serial_if.slave  bus
);

   localparam int NSTEP = 16 / LANES;
   localparam int CW    = $clog2(NSTEP) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e          state_q;
   logic [127:0]    w_q;
   logic [CW-1:0]   cnt_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;
   logic [127:0]    w_sub_d;

   // Next W during SUB: only the byte group selected by cnt goes through the S-box.
   always_comb begin
      w_sub_d = w_q;
      for (int k = 0; k < 16; k++) begin
         if (CW'(k / LANES) == cnt_q) begin
            w_sub_d[127-8*k -: 8] = SBOX[w_q[127-8*k -: 8]];
         end else begin
            w_sub_d[127-8*k -: 8] = w_q[127-8*k -: 8];
         end
      end
   end

   // Control FSM, working register and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  w_q        <= bus.state_in;
                  cnt_q      <= '0;
                  state_q    <= ST_SUB;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_SUB: begin
               w_q   <= w_sub_d;
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= '0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.state_out = w_q;

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Sequential SubBytes stage for the AES-128 datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES instances of the byte S-box substitution table. It returns the substituted state over a second valid/ready handshake. It sits between the AddRoundKey output and the ShiftRows input, and trades latency for S-box area.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; derived NSTEP = 16/LANES.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a state; high only in IDLE.
- state_in  input  128  state to substitute; byte k = bits [127-8k -: 8], byte 0 most significant (FIPS-197 order).
- out_valid  output  1  state_out holds a complete result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  substituted state, same byte order.
- busy  output  1  high in SUB and HOLD.

## Operation
- Internal registers: 128-bit working register W, step counter cnt of width ceil(log2(NSTEP))+1, and a 2-bit state.
- IDLE: in_ready=1.
  - On in_valid at a rising edge: W <= state_in, cnt <= 0, go to SUB.
  - Otherwise W is held.
- SUB: each edge, bytes cnt*LANES .. cnt*LANES+LANES-1 of W are replaced by their S-box images, and cnt increments.
  - The edge on which cnt = NSTEP-1 writes the last group and moves to HOLD.
  - in_valid is ignored; in_ready=0.
- HOLD: out_valid=1 and W is frozen.
  - On out_ready at an edge: go to IDLE.
  - Otherwise stay in HOLD indefinitely.
- state_out = W continuously. Its value is meaningful only while out_valid=1.
- Bytes not in the current group pass through unchanged. Each byte is substituted exactly once per block.
- The S-box is the fixed AES forward table (0x00->0x63, 0x53->0xED, 0xFF->0x16). The lookup is combinational within the cycle.
- No accept in HOLD. A new block is taken only after returning to IDLE.

## Timing
- Reset (asynchronous assert, any time, including mid-SUB or HOLD):
  - State is IDLE, W=0, cnt=0.
  - out_valid=0, busy=0, in_ready=1, state_out=0.
  - Any in-flight block is discarded with no partial output.
- Release: the first accepting edge is the first rising edge after rst deasserts.
- Latency: the input handshake occurs on edge E0. out_valid rises after edge E(NSTEP) and is visible in the cycle following it.
  - LANES=4: 4 cycles.
  - LANES=1: 16 cycles.
  - LANES=16: 1 cycle.
- Throughput with out_ready tied high: one block per NSTEP+2 cycles. The sequence is accept, NSTEP SUB edges, HOLD edge, then IDLE for one cycle.
- out_valid, busy and in_ready are decoded from registered state only, with no combinational input-to-output path.
- Backpressure: while out_valid=1 and out_ready=0, state_out and out_valid remain stable every cycle.
- Simultaneous in_valid and out_ready in HOLD: the output is consumed, and the input is not accepted until IDLE.

## Test plan
- FIPS-197 App. B round 1, LANES=4: state_in=193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=d42711aee0bf98f1b8b45de51e415230, with out_valid exactly 4 cycles after the accept edge.
- Constant states: all-zero input -> 63 repeated ×16; all-FF input -> 16 repeated ×16. Repeat for LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - state_out and out_valid stay unchanged; in_ready stays 0.
  - After out_ready=1, in_ready=1 exactly one cycle later.
- Busy-input rejection: pulse in_valid with 000102...0f during SUB.
  - The result is still d42711ae... from the first block.
  - No second out_valid occurs without a new accept.
- Mid-operation reset: assert rst asynchronously at cnt=2.
  - Immediately out_valid=0, busy=0, state_out=0, in_ready=1.
  - The next block, 00112233445566778899aabbccddeeff, yields 638293c31bfc33f5c4eeacea4bc12816.
- Back-to-back streaming with out_ready=1, 8 random blocks: results match a software S-box model, arrive in order, and blocks are spaced at NSTEP+2 cycles.
